// File: rtl/morse_stream_decoder.sv
// Morse DIT/DAH stream to ASCII decoder feeding a FWFT output FIFO; a char appears 1 cycle after its GAP/SPACE.
// Backpressure: letterValid/letterReady drain; a push into a full FIFO without a pop is dropped and flags overrun.
`timescale 1ns/1ps
module morse_stream_decoder #(
    parameter int MAX_ELEMS  = 5,
    parameter int DIGITS_EN  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       inputSignal,
    output logic [7:0]       letter,
    output logic             letterValid,
    input  logic             letterReady,
    output logic             badCode,
    output logic             overrun,
    output logic [CNT_W-1:0] count
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [2:0]       MAX_LEN = 3'(MAX_ELEMS);
    localparam logic [CNT_W-1:0] DEPTH   = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] SYM_DIT   = 3'd1;
    localparam logic [2:0] SYM_DAH   = 3'd2;
    localparam logic [2:0] SYM_GAP   = 3'd3;
    localparam logic [2:0] SYM_SPACE = 3'd4;

    typedef enum logic {COLLECT, EMIT_SP} state_t;

    state_t               state, state_n;
    logic [MAX_ELEMS-1:0] code, code_n;
    logic [2:0]           len, len_n;
    logic                 ovf, ovf_n;
    logic                 last_space, last_space_n;
    logic                 push, bad_n, sym_drop;
    logic [7:0]           push_dat;
    logic [8:0]           lu;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             pop, full, push_ok, drop;

    // Result is {hit, ascii}; a zero ascii means the (len, code) pair is unmapped.
    function automatic logic [8:0] lookup(input logic [2:0] l, input logic [5:0] c);
        logic [7:0] a;
        a = 8'h00;
        case ({l, c})
            {3'd1, 6'b000000}: a = "E";  {3'd1, 6'b000001}: a = "T";
            {3'd2, 6'b000000}: a = "I";  {3'd2, 6'b000001}: a = "A";
            {3'd2, 6'b000010}: a = "N";  {3'd2, 6'b000011}: a = "M";
            {3'd3, 6'b000000}: a = "S";  {3'd3, 6'b000001}: a = "U";
            {3'd3, 6'b000010}: a = "R";  {3'd3, 6'b000011}: a = "W";
            {3'd3, 6'b000100}: a = "D";  {3'd3, 6'b000101}: a = "K";
            {3'd3, 6'b000110}: a = "G";  {3'd3, 6'b000111}: a = "O";
            {3'd4, 6'b000000}: a = "H";  {3'd4, 6'b000001}: a = "V";
            {3'd4, 6'b000010}: a = "F";  {3'd4, 6'b000100}: a = "L";
            {3'd4, 6'b000110}: a = "P";  {3'd4, 6'b000111}: a = "J";
            {3'd4, 6'b001000}: a = "B";  {3'd4, 6'b001001}: a = "X";
            {3'd4, 6'b001010}: a = "C";  {3'd4, 6'b001011}: a = "Y";
            {3'd4, 6'b001100}: a = "Z";  {3'd4, 6'b001101}: a = "Q";
            default: a = 8'h00;
        endcase
        if (DIGITS_EN != 0 && l == 3'd5) begin
            case (c)
                6'b011111: a = "0";  6'b001111: a = "1";
                6'b000111: a = "2";  6'b000011: a = "3";
                6'b000001: a = "4";  6'b000000: a = "5";
                6'b010000: a = "6";  6'b011000: a = "7";
                6'b011100: a = "8";  6'b011110: a = "9";
                default:   a = 8'h00;
            endcase
        end
        return {a != 8'h00, a};
    endfunction

    assign lu = lookup(len, 6'(code));

    always_comb begin
        state_n      = state;
        code_n       = code;
        len_n        = len;
        ovf_n        = ovf;
        last_space_n = last_space;
        push         = 1'b0;
        push_dat     = 8'h00;
        bad_n        = 1'b0;
        sym_drop     = 1'b0;
        case (state)
            COLLECT: begin
                case (inputSignal)
                    SYM_DIT, SYM_DAH: begin
                        if (len < MAX_LEN) begin
                            code_n = {code[MAX_ELEMS-2:0], inputSignal == SYM_DAH};
                            len_n  = len + 3'd1;
                        end else begin
                            ovf_n = 1'b1;
                        end
                    end
                    SYM_GAP, SYM_SPACE: begin
                        if (len != 3'd0) begin
                            push = 1'b1;
                            if (lu[8] && !ovf) begin
                                push_dat = lu[7:0];
                            end else begin
                                push_dat = 8'h3F;
                                bad_n    = 1'b1;
                            end
                            code_n       = '0;
                            len_n        = 3'd0;
                            ovf_n        = 1'b0;
                            last_space_n = 1'b0;
                            if (inputSignal == SYM_SPACE) state_n = EMIT_SP;
                        end else if (inputSignal == SYM_SPACE && !last_space) begin
                            push         = 1'b1;
                            push_dat     = 8'h20;
                            last_space_n = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            EMIT_SP: begin
                push         = 1'b1;
                push_dat     = 8'h20;
                last_space_n = 1'b1;
                state_n      = COLLECT;
                // Codes 5-7 count as WAIT, so only 1..4 are lost here.
                sym_drop     = (inputSignal >= SYM_DIT) && (inputSignal <= SYM_SPACE);
            end
            default: state_n = COLLECT;
        endcase
    end

    assign letterValid = (cnt != '0);
    assign full        = (cnt == DEPTH);
    assign pop         = letterValid && letterReady;
    assign push_ok     = push && (!full || pop);
    assign drop        = push && full && !pop;
    assign letter      = letterValid ? mem[rd_ptr] : 8'h00;
    assign count       = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= COLLECT;
            code       <= '0;
            len        <= 3'd0;
            ovf        <= 1'b0;
            last_space <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            badCode    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            code       <= code_n;
            len        <= len_n;
            ovf        <= ovf_n;
            last_space <= last_space_n;
            badCode    <= bad_n;
            overrun    <= drop | sym_drop;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: tb/tb_morse_stream_decoder.sv
// Directed bench for morse_stream_decoder: default, no-digit and 4-element instances share one stimulus stream.
`timescale 1ns/1ps
module tb_morse_stream_decoder;
    localparam logic [2:0] WAIT = 3'd0, DIT = 3'd1, DAH = 3'd2, GAP = 3'd3, SPACE = 3'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] inputSignal = WAIT;
    logic       letterReady = 1'b0;

    logic [7:0] letter, letter_nd, letter_m4;
    logic       letterValid, letterValid_nd, letterValid_m4;
    logic       badCode, badCode_nd, badCode_m4;
    logic       overrun, overrun_nd, overrun_m4;
    logic [2:0] count, count_nd, count_m4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    morse_stream_decoder dut (
        .clk(clk), .reset(reset), .inputSignal(inputSignal),
        .letter(letter), .letterValid(letterValid), .letterReady(letterReady),
        .badCode(badCode), .overrun(overrun), .count(count)
    );

    morse_stream_decoder #(.DIGITS_EN(0)) dut_nd (
        .clk(clk), .reset(reset), .inputSignal(inputSignal),
        .letter(letter_nd), .letterValid(letterValid_nd), .letterReady(letterReady),
        .badCode(badCode_nd), .overrun(overrun_nd), .count(count_nd)
    );

    morse_stream_decoder #(.MAX_ELEMS(4)) dut_m4 (
        .clk(clk), .reset(reset), .inputSignal(inputSignal),
        .letter(letter_m4), .letterValid(letterValid_m4), .letterReady(letterReady),
        .badCode(badCode_m4), .overrun(overrun_m4), .count(count_m4)
    );

    // Apply a symbol for one clock; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic [2:0] s);
        inputSignal = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(WAIT);
        cyc(WAIT);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        letterReady = 1'b0;
        do_reset();
        checks++;
        if ({letter, letterValid, badCode, overrun, count} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs got letter=%h vld=%b bad=%b ovr=%b cnt=%0d want all 0",
                     letter, letterValid, badCode, overrun, count);
        end
    endtask

    task automatic test_letter_a();
        int vld_cycles;
        do_reset();
        letterReady = 1'b1;
        cyc(DIT); cyc(WAIT); cyc(DAH);
        checks++;
        if (letterValid !== 1'b0) begin
            errors++; $display("FAIL a_before_gap got vld=%b want 0", letterValid);
        end
        cyc(GAP);
        checks++;
        if (letterValid !== 1'b1 || letter !== 8'h41) begin
            errors++; $display("FAIL a_letter got vld=%b letter=%h want 1/41", letterValid, letter);
        end
        vld_cycles = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(WAIT);
            if (letterValid) vld_cycles++;
        end
        checks++;
        if (vld_cycles !== 1 || count !== 3'd0) begin
            errors++; $display("FAIL a_one_cycle got vld_cycles=%0d cnt=%0d want 1/0", vld_cycles, count);
        end
    endtask

    task automatic test_digit();
        do_reset();
        letterReady = 1'b1;
        for (int i = 0; i < 5; i++) cyc(DAH);
        cyc(GAP);
        checks++;
        if (letterValid !== 1'b1 || letter !== 8'h30 || badCode !== 1'b0) begin
            errors++; $display("FAIL digit_zero got vld=%b letter=%h bad=%b want 1/30/0", letterValid, letter, badCode);
        end
        checks++;
        if (letterValid_nd !== 1'b1 || letter_nd !== 8'h3F || badCode_nd !== 1'b1) begin
            errors++; $display("FAIL digit_disabled got vld=%b letter=%h bad=%b want 1/3f/1",
                               letterValid_nd, letter_nd, badCode_nd);
        end
        cyc(WAIT);
        checks++;
        if (badCode_nd !== 1'b0 || count_nd !== 3'd0) begin
            errors++; $display("FAIL digit_bad_pulse got bad=%b cnt=%0d want 0/0", badCode_nd, count_nd);
        end
    endtask

    task automatic test_overlong();
        int pulses;
        do_reset();
        letterReady = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(DIT);
            pulses += int'(badCode_m4);
        end
        cyc(GAP);
        pulses += int'(badCode_m4);
        checks++;
        if (letterValid_m4 !== 1'b1 || letter_m4 !== 8'h3F) begin
            errors++; $display("FAIL overlong_char got vld=%b letter=%h want 1/3f", letterValid_m4, letter_m4);
        end
        cyc(WAIT);
        pulses += int'(badCode_m4);
        cyc(DIT);
        pulses += int'(badCode_m4);
        cyc(GAP);
        pulses += int'(badCode_m4);
        checks++;
        if (letterValid_m4 !== 1'b1 || letter_m4 !== 8'h45) begin
            errors++; $display("FAIL overlong_recover got vld=%b letter=%h want 1/45", letterValid_m4, letter_m4);
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL overlong_bad_pulses got %0d want 1", pulses);
        end
        cyc(WAIT);
    endtask

    task automatic test_space();
        do_reset();
        letterReady = 1'b1;
        cyc(SPACE);
        checks++;
        if (letterValid !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL leading_space got vld=%b cnt=%0d want 0/0", letterValid, count);
        end
        cyc(DIT);
        cyc(SPACE);
        checks++;
        if (letterValid !== 1'b1 || letter !== 8'h45) begin
            errors++; $display("FAIL space_e got vld=%b letter=%h want 1/45", letterValid, letter);
        end
        // Second SPACE lands in the space-emit cycle and is dropped.
        cyc(SPACE);
        checks++;
        if (letterValid !== 1'b1 || letter !== 8'h20 || overrun !== 1'b1) begin
            errors++; $display("FAIL space_sp got vld=%b letter=%h ovr=%b want 1/20/1", letterValid, letter, overrun);
        end
        cyc(DAH);
        checks++;
        if (letterValid !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL space_single got vld=%b ovr=%b want 0/0", letterValid, overrun);
        end
        cyc(GAP);
        checks++;
        if (letterValid !== 1'b1 || letter !== 8'h54) begin
            errors++; $display("FAIL space_t got vld=%b letter=%h want 1/54", letterValid, letter);
        end
        cyc(SPACE);
        checks++;
        if (letterValid !== 1'b1 || letter !== 8'h20) begin
            errors++; $display("FAIL word_space got vld=%b letter=%h want 1/20", letterValid, letter);
        end
        cyc(SPACE);
        checks++;
        if (letterValid !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL space_collapse got vld=%b cnt=%0d want 0/0", letterValid, count);
        end
    endtask

    task automatic test_full();
        int pulses;
        do_reset();
        letterReady = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(DIT);
            pulses += int'(overrun);
            cyc(GAP);
            pulses += int'(overrun);
            if (i == 3) begin
                checks++;
                if (count !== 3'd4) begin
                    errors++; $display("FAIL full_count got %0d want 4", count);
                end
            end
        end
        checks++;
        if (count !== 3'd4 || overrun !== 1'b1 || pulses !== 1) begin
            errors++; $display("FAIL full_drop got cnt=%0d ovr=%b pulses=%0d want 4/1/1", count, overrun, pulses);
        end
        cyc(DIT);
        letterReady = 1'b1;
        cyc(GAP);
        letterReady = 1'b0;
        checks++;
        if (count !== 3'd4 || overrun !== 1'b0 || letter !== 8'h45) begin
            errors++; $display("FAIL back_to_back got cnt=%0d ovr=%b letter=%h want 4/0/45", count, overrun, letter);
        end
        letterReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (letterValid !== 1'b1 || letter !== 8'h45) begin
                errors++; $display("FAIL drain_%0d got vld=%b letter=%h want 1/45", i, letterValid, letter);
            end
            cyc(WAIT);
        end
        checks++;
        if (letterValid !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL drain_empty got vld=%b cnt=%0d want 0/0", letterValid, count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        letterReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(DIT);
            cyc(GAP);
        end
        cyc(DIT);
        cyc(DAH);
        checks++;
        if (count !== 3'd3) begin
            errors++; $display("FAIL mid_fill got cnt=%0d want 3", count);
        end
        reset = 1'b1;
        cyc(WAIT);
        reset = 1'b0;
        checks++;
        if (count !== 3'd0 || letterValid !== 1'b0 || letter !== 8'h00) begin
            errors++; $display("FAIL mid_reset got cnt=%0d vld=%b letter=%h want 0/0/00", count, letterValid, letter);
        end
        letterReady = 1'b1;
        cyc(DIT);
        cyc(GAP);
        checks++;
        if (letterValid !== 1'b1 || letter !== 8'h45) begin
            errors++; $display("FAIL mid_after got vld=%b letter=%h want 1/45", letterValid, letter);
        end
        cyc(WAIT);
    endtask

    initial begin
        test_reset();
        test_letter_a();
        test_digit();
        test_overlong();
        test_space();
        test_full();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
